// File: rtl/drain_timer.sv
// drain_timer: sequences output deskew capture and row handoff while a systolic array drains.
// Optional sticky protocol-error flag is built only when DRAIN_TIMER_ERR_EN is defined.
module drain_timer #(
  parameter int N = 4,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         out_ready,
  output logic [N-1:0] col_capture,
  output logic         row_valid,
  output logic [$clog2(N)-1:0] row_idx,
  output logic         array_stall,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int D  = N + LATENCY;
  localparam int CW = $clog2(2 * N + LATENCY);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // cnt is the wait counter in WAIT and the drain index k in DRAIN
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_capture = '0;
    row_valid   = 1'b0;
    row_idx     = '0;
    array_stall = 1'b0;
    busy        = state_q != IDLE;
    done        = state_q == DONE;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? WAIT : IDLE;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(D - 2)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      default: begin
        row_valid   = cnt_q >= CW'(N - 1);
        array_stall = row_valid & ~out_ready;
        row_idx     = row_valid ? IW'(cnt_q - CW'(N - 1)) : '0;
        for (int j = 0; j < N; j++)
          col_capture[j] = !array_stall && int'(cnt_q) >= j && int'(cnt_q) - j <= N - 1;
        if (!array_stall) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = cnt_q == CW'(2 * N - 2) ? DONE : DRAIN;
        end
      end
    endcase
  end
`ifdef DRAIN_TIMER_ERR_EN
  logic err_q, err_d;
  assign err_d = err_q | (start & (state_q == WAIT || state_q == DRAIN));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_drain_timer.sv
// tb_drain_timer: directed scenarios checked every cycle against a timeline model of the drain.
module tb_drain_timer;
  localparam int N = 4;
  localparam int LATENCY = 1;
  localparam int D = N + LATENCY;
  localparam int CYC = 40;
`ifdef DRAIN_TIMER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [N-1:0] col_capture;
  logic row_valid, array_stall, busy, done, err;
  logic [$clog2(N)-1:0] row_idx;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] smask, rmask, xmask;
  logic [N-1:0] cc_o [0:CYC-1];
  logic rv_o [0:CYC-1], st_o [0:CYC-1], bz_o [0:CYC-1], dn_o [0:CYC-1], er_o [0:CYC-1];
  int ri_o [0:CYC-1];
  string scen;

  drain_timer #(.N(N), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
    .col_capture(col_capture), .row_valid(row_valid), .row_idx(row_idx),
    .array_stall(array_stall), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int c, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s %s cycle %0d: got %0d expected %0d", scen, nm, c, act, exp);
    end
  endtask

  // Timeline model: the drain index is elapsed time since start minus D minus stall cycles.
  task automatic run(input string nm, input logic [63:0] s, input logic [63:0] r, input logic [63:0] x);
    bit act = 0, dn = 0, err_m = 0;
    int st = 0, stalls = 0;
    scen = nm;
    smask = s; rmask = r; xmask = x;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int c = 0; c < CYC; c++) begin
      int k;
      bit e_rv, e_st, e_bz, e_dn;
      logic [N-1:0] e_cc;
      int e_ri;
      @(posedge clk);
      #1;
      rst = xmask[c]; start = smask[c]; out_ready = !rmask[c];
      k = -1; e_rv = 0; e_st = 0; e_bz = 0; e_dn = 0; e_cc = '0; e_ri = 0;
      if (rst) begin
        act = 0; dn = 0; err_m = 0;
      end else if (dn) begin
        e_bz = 1; e_dn = 1;
      end else if (act) begin
        e_bz = 1;
        k = c - st - D - stalls;
        if (k >= 0) begin
          e_rv = k >= N - 1;
          e_st = e_rv && !out_ready;
          e_ri = e_rv ? k - (N - 1) : 0;
          for (int j = 0; j < N; j++) e_cc[j] = !e_st && k - j >= 0 && k - j <= N - 1;
        end
      end
      @(negedge clk);
      cc_o[c] = col_capture; rv_o[c] = row_valid; ri_o[c] = int'(row_idx);
      st_o[c] = array_stall; bz_o[c] = busy; dn_o[c] = done; er_o[c] = err;
      chk("col_capture", c, int'(col_capture), int'(e_cc));
      chk("row_valid", c, int'(row_valid), int'(e_rv));
      chk("row_idx", c, int'(row_idx), e_ri);
      chk("array_stall", c, int'(array_stall), int'(e_st));
      chk("busy", c, int'(busy), int'(e_bz));
      chk("done", c, int'(done), int'(e_dn));
      chk("err", c, int'(err), int'(err_m));
      if (!rst) begin
        if (dn) begin
          dn = 0;
          if (start) begin act = 1; st = c; stalls = 0; end
        end else if (act) begin
          if (start && ERR_EN) err_m = 1;
          if (k >= 0) begin
            if (e_st) stalls++;
            else if (k == 2 * N - 2) begin act = 0; dn = 1; end
          end
        end else if (start) begin
          act = 1; st = c; stalls = 0;
        end
      end
    end
  endtask

  initial begin
    run("basic", 64'h1, 64'h0, 64'h0);
    chk("pin_cc0_c5", 5, int'(cc_o[5]), 1);
    chk("pin_cc_c8", 8, int'(cc_o[8]), 15);
    chk("pin_cc3_c11", 11, int'(cc_o[11]), 8);
    chk("pin_rv_c7", 7, int'(rv_o[7]), 0);
    chk("pin_ri_c11", 11, ri_o[11], 3);
    chk("pin_done_c12", 12, int'(dn_o[12]), 1);
    chk("pin_busy_c13", 13, int'(bz_o[13]), 0);
    run("stall", 64'h1, 64'h600, 64'h0);
    chk("pin_stall_c9", 9, int'(st_o[9]), 1);
    chk("pin_ri_c10", 10, ri_o[10], 1);
    chk("pin_cc_c10", 10, int'(cc_o[10]), 0);
    chk("pin_done_c14", 14, int'(dn_o[14]), 1);
    run("restart", 64'h41, 64'h0, 64'h0);
    chk("pin_done_c12", 12, int'(dn_o[12]), 1);
    chk("pin_err_c7", 7, int'(er_o[7]), int'(ERR_EN));
    run("reset", 64'h201, 64'h0, 64'h180);
    chk("pin_busy_c7", 7, int'(bz_o[7]), 0);
    chk("pin_done_c12", 12, int'(dn_o[12]), 0);
    chk("pin_cc0_c14", 14, int'(cc_o[14]), 1);
    chk("pin_done_c21", 21, int'(dn_o[21]), 1);
    run("back2back", 64'h1001, 64'h0, 64'h0);
    chk("pin_busy_c13", 13, int'(bz_o[13]), 1);
    chk("pin_cc_c16", 16, int'(cc_o[16]), 0);
    chk("pin_cc0_c17", 17, int'(cc_o[17]), 1);
    run("mixed", 64'h0000_0000_0020_0003, 64'h0000_0000_0000_3900, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
